// File: rtl/nios_fast_oci_cmd_scheduler.sv
// JTAG debug command scheduler: queues take_action strobes, executes them in order against
// the OCI RAM / break registers, and shares the RAM port round-robin with CPU monitor accesses.
module nios_fast_oci_cmd_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_action_break_a,
  input  logic              take_action_break_b,
  input  logic              take_action_break_c,
  input  logic [37:0]       jdo,
  input  logic              clr_overflow,
  output logic              cmd_overflow,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              mon_rvalid,
  output logic [31:0]       mon_rdata,
  output logic              brk_wr,
  output logic [1:0]        brk_sel,
  output logic [31:0]       brk_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = FIFO_DEPTH[PTR_W:0];

  typedef enum logic [2:0] {OP_MEM_A, OP_MEM_B, OP_BRK_A, OP_BRK_B, OP_BRK_C} op_t;
  typedef enum logic [2:0] {IDLE, J_ISSUE, J_RDWAIT, C_ISSUE, C_RDWAIT} state_t;
  typedef enum logic {GNT_CPU, GNT_JTAG} grant_t;

  typedef struct packed {
    op_t         op;
    logic        rd;
    logic [31:0] data;
  } cmd_t;

  cmd_t              fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  state_t            state;
  grant_t            last_grant;
  logic [ADDR_W-1:0] addr_ptr;

  logic [4:0]        strobes;
  logic              any_strobe, multi_strobe, fifo_full, enq, pop;
  cmd_t              new_cmd, head;
  logic [ADDR_W-1:0] head_addr;
  logic              unused_jdo_bits;

  always_comb begin
    strobes      = {take_action_break_c, take_action_break_b, take_action_break_a,
                    take_action_ocimem_b, take_action_ocimem_a};
    any_strobe   = |strobes;
    multi_strobe = (strobes & (strobes - 5'd1)) != '0;
    new_cmd.rd   = jdo[35];
    new_cmd.data = jdo[31:0];
    if (take_action_ocimem_a)      new_cmd.op = OP_MEM_A;
    else if (take_action_ocimem_b) new_cmd.op = OP_MEM_B;
    else if (take_action_break_a)  new_cmd.op = OP_BRK_A;
    else if (take_action_break_b)  new_cmd.op = OP_BRK_B;
    else                           new_cmd.op = OP_BRK_C;
    fifo_full = (count == DEPTH_CNT);
    head      = fifo_mem[rd_ptr];
    head_addr = head.data[ADDR_W-1:0];
    // JTAG wins IDLE unless the CPU is waiting and JTAG had the previous turn
    pop = (state == IDLE) && (count != '0) && (!cpu_req || last_grant == GNT_CPU);
    enq = any_strobe && (!fifo_full || pop);
    unused_jdo_bits = ^{jdo[37:36], jdo[34:32]};
  end

  always_ff @(posedge clk) begin
    if (enq) fifo_mem[wr_ptr] <= new_cmd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      cmd_overflow <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (clr_overflow)                            cmd_overflow <= 1'b0;
      else if (multi_strobe || (any_strobe && !enq)) cmd_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GNT_CPU;
      addr_ptr   <= '0;
      ram_en     <= 1'b0;
      ram_wr     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      cpu_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      mon_rvalid <= 1'b0;
      mon_rdata  <= '0;
      brk_wr     <= 1'b0;
      brk_sel    <= '0;
      brk_data   <= '0;
    end else begin
      ram_en     <= 1'b0;
      ram_wr     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      cpu_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      mon_rvalid <= 1'b0;
      brk_wr     <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            last_grant <= GNT_JTAG;
            case (head.op)
              OP_MEM_A: begin
                if (head.rd) begin
                  addr_ptr <= head_addr + ADDR_W'(1);
                  ram_en   <= 1'b1;
                  ram_addr <= head_addr;
                  state    <= J_ISSUE;
                end else begin
                  addr_ptr <= head_addr;
                end
              end
              OP_MEM_B: begin
                addr_ptr  <= addr_ptr + ADDR_W'(1);
                ram_en    <= 1'b1;
                ram_wr    <= 1'b1;
                ram_addr  <= addr_ptr;
                ram_wdata <= head.data;
                state     <= J_ISSUE;
              end
              default: begin
                brk_wr   <= 1'b1;
                brk_data <= head.data;
                case (head.op)
                  OP_BRK_A: brk_sel <= 2'd0;
                  OP_BRK_B: brk_sel <= 2'd1;
                  default:  brk_sel <= 2'd2;
                endcase
              end
            endcase
          end else if (cpu_req) begin
            last_grant <= GNT_CPU;
            cpu_gnt    <= 1'b1;
            ram_en     <= 1'b1;
            ram_wr     <= cpu_wr;
            ram_addr   <= cpu_addr;
            ram_wdata  <= cpu_wr ? cpu_wdata : '0;
            state      <= C_ISSUE;
          end
        end
        // ram_wr still holds the direction of the access issued this cycle
        J_ISSUE: state <= ram_wr ? IDLE : J_RDWAIT;
        C_ISSUE: state <= ram_wr ? IDLE : C_RDWAIT;
        J_RDWAIT: begin
          mon_rvalid <= 1'b1;
          mon_rdata  <= ram_rdata;
          state      <= IDLE;
        end
        C_RDWAIT: begin
          cpu_rvalid <= 1'b1;
          cpu_rdata  <= ram_rdata;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
